// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall FSM and branch flush.
// Optional performance counters are enabled with the macro HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 32,
  localparam int unsigned RW      = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [RW-1:0]    ex_rs1,
  input  logic [RW-1:0]    ex_rs2,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_wren,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic [RW-1:0]    mem_rd,
  input  logic             mem_wren,
  input  logic [RW-1:0]    wb_rd,
  input  logic             wb_wren,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned CW = $clog2(LOAD_LAT + 1);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] LDSTALL = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          branch_c;
  logic          load_use_c;

  // MEM result is younger than WB, so it wins; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src,
                                         input logic [RW-1:0] m_rd, input logic m_we,
                                         input logic [RW-1:0] w_rd, input logic w_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd == src) && (m_rd != '0))
      sel = 2'b01;
    else if (w_we && (w_rd == src) && (w_rd != '0))
      sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (rst) begin
      fwd_a_sel = fwd_sel(ex_rs1, mem_rd, mem_wren, wb_rd, wb_wren);
      fwd_b_sel = fwd_sel(ex_rs2, mem_rd, mem_wren, wb_rd, wb_wren);
    end
  end

  assign branch_c   = ex_valid & ex_br_taken;
  assign load_use_c = ex_valid & ex_is_load & ex_wren & (ex_rd != '0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and stall/flush outputs; a taken branch overrides any stall.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    if (branch_c) begin
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      cnt_nxt   = '0;
      state_nxt = RUN;
    end else if (state == RUN) begin
      if (load_use_c) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        flush_ex  = 1'b1;
        cnt_nxt   = CW'(LOAD_LAT - 1);
        state_nxt = (LOAD_LAT > 1) ? LDSTALL : RUN;
      end
    end else begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      flush_ex  = 1'b1;
      cnt_nxt   = (cnt == '0) ? '0 : cnt - CW'(1);
      state_nxt = (cnt <= CW'(1)) ? RUN : LDSTALL;
    end
    if (!rst) begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_if && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_id && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (LOAD_LAT=3 and LOAD_LAT=1)
// share stimulus and are compared every cycle against an abstract stall-budget model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned NREG  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_rs1_used, id_rs2_used, ex_valid, ex_wren, ex_is_load, ex_br_taken, mem_wren, wb_wren;

  logic [1:0]       stall_if_v, stall_id_v, flush_id_v, flush_ex_v;
  logic [1:0]       fwd_a_v [2];
  logic [1:0]       fwd_b_v [2];
  logic [CNT_W-1:0] scnt_v [2];
  logic [CNT_W-1:0] fcnt_v [2];

  int lat [2] = '{3, 1};
  int stall_left [2];
  int m_scnt [2];
  int m_fcnt [2];
  bit e_stall [2];
  bit e_fid [2];
  bit e_fex [2];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NREG(NREG), .LOAD_LAT(3), .CNT_W(CNT_W)) u_dut3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wren(ex_wren),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken), .mem_rd(mem_rd),
    .mem_wren(mem_wren), .wb_rd(wb_rd), .wb_wren(wb_wren),
    .stall_if(stall_if_v[0]), .stall_id(stall_id_v[0]), .flush_id(flush_id_v[0]),
    .flush_ex(flush_ex_v[0]), .fwd_a_sel(fwd_a_v[0]), .fwd_b_sel(fwd_b_v[0]),
    .stall_cnt(scnt_v[0]), .flush_cnt(fcnt_v[0]));

  pipe_hazard_ctrl #(.NREG(NREG), .LOAD_LAT(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_wren(ex_wren),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken), .mem_rd(mem_rd),
    .mem_wren(mem_wren), .wb_rd(wb_rd), .wb_wren(wb_wren),
    .stall_if(stall_if_v[1]), .stall_id(stall_id_v[1]), .flush_id(flush_id_v[1]),
    .flush_ex(flush_ex_v[1]), .fwd_a_sel(fwd_a_v[1]), .fwd_b_sel(fwd_b_v[1]),
    .stall_cnt(scnt_v[1]), .flush_cnt(fcnt_v[1]));

  function automatic bit hazard();
    return ex_valid && ex_is_load && ex_wren && (ex_rd != 0) &&
           ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
  endfunction

  function automatic int fwd_model(input logic [RW-1:0] src);
    if (src == 0) return 0;
    if (mem_wren && mem_rd == src) return 1;
    if (wb_wren && wb_rd == src) return 2;
    return 0;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (dut%0d) @%0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_valid, ex_wren, ex_is_load, ex_br_taken, mem_wren, wb_wren} = '0;
  endtask

  task automatic set_ld_hazard();
    clear_inputs();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_wren = 1'b1; ex_rd = 5'd7;
    id_rs2 = 5'd7; id_rs2_used = 1'b1;
  endtask

  // Compare both DUTs against the model at the current (settled) input set.
  task automatic sample();
    bit br;
    bit hz;
    #1;
    br = ex_valid && ex_br_taken;
    hz = hazard();
    for (int d = 0; d < 2; d++) begin
      int ea;
      int eb;
      ea = 0; eb = 0;
      if (!rst) begin
        stall_left[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
        e_stall[d] = 0; e_fid[d] = 0; e_fex[d] = 0;
      end else begin
        ea = fwd_model(ex_rs1);
        eb = fwd_model(ex_rs2);
        e_fid[d]   = br;
        e_stall[d] = !br && (stall_left[d] > 0 || hz);
        e_fex[d]   = br || e_stall[d];
      end
      chk("stall_if", d, int'(stall_if_v[d]), int'(e_stall[d]));
      chk("stall_id", d, int'(stall_id_v[d]), int'(e_stall[d]));
      chk("flush_id", d, int'(flush_id_v[d]), int'(e_fid[d]));
      chk("flush_ex", d, int'(flush_ex_v[d]), int'(e_fex[d]));
      chk("fwd_a_sel", d, int'(fwd_a_v[d]), ea);
      chk("fwd_b_sel", d, int'(fwd_b_v[d]), eb);
      chk("stall_cnt", d, int'(scnt_v[d]), PERF ? m_scnt[d] : 0);
      chk("flush_cnt", d, int'(fcnt_v[d]), PERF ? m_fcnt[d] : 0);
    end
  endtask

  task automatic advance();
    bit br;
    bit hz;
    br = ex_valid && ex_br_taken;
    hz = hazard();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        if (br) stall_left[d] = 0;
        else if (stall_left[d] > 0) stall_left[d]--;
        else if (hz) stall_left[d] = lat[d] - 1;
        if (e_stall[d] && m_scnt[d] < CMAX) m_scnt[d]++;
        if (e_fid[d] && m_fcnt[d] < CMAX) m_fcnt[d]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sample();
    advance();
    rst = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      stall_left[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
      e_stall[d] = 0; e_fid[d] = 0; e_fex[d] = 0;
    end
    // Reset with hazard and forwarding inputs active: everything must read 0.
    set_ld_hazard();
    mem_wren = 1'b1; mem_rd = 5'd3; ex_rs1 = 5'd3;
    @(negedge clk);
    sample();
    chk("rst_stall_if", 0, int'(stall_if_v[0]), 0);
    chk("rst_fwd_a", 0, int'(fwd_a_v[0]), 0);
    chk("rst_stall_cnt", 0, int'(scnt_v[0]), 0);
    advance();
    clear_inputs();
    rst = 1'b1;

    // Forward priority: MEM over WB, then WB alone.
    mem_rd = 5'd5; mem_wren = 1'b1; wb_rd = 5'd5; wb_wren = 1'b1; ex_rs1 = 5'd5;
    sample();
    chk("fwd_mem_prio", 0, int'(fwd_a_v[0]), 1);
    mem_wren = 1'b0;
    sample();
    chk("fwd_wb", 0, int'(fwd_a_v[0]), 2);
    advance();

    // Single load-use stall: LOAD_LAT=1 stalls one cycle, LOAD_LAT=3 three.
    set_ld_hazard();
    sample();
    chk("ll1_stall_c1", 1, int'(stall_if_v[1]), 1);
    chk("ll1_flush_ex_c1", 1, int'(flush_ex_v[1]), 1);
    chk("ll3_stall_c1", 0, int'(stall_if_v[0]), 1);
    advance();
    clear_inputs();
    sample();
    chk("ll1_stall_c2", 1, int'(stall_if_v[1]), 0);
    chk("ll1_flush_ex_c2", 1, int'(flush_ex_v[1]), 0);
    chk("ll3_stall_c2", 0, int'(stall_id_v[0]), 1);
    advance();
    sample();
    chk("ll3_stall_c3", 0, int'(stall_if_v[0]), 1);
    advance();
    sample();
    chk("ll3_stall_c4", 0, int'(stall_if_v[0]), 0);
    advance();

    // Hazard held during the LOAD_LAT=3 stall does not extend it.
    set_ld_hazard();
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("ll3_hold_stall", 0, int'(stall_if_v[0]), 1);
      advance();
    end
    clear_inputs();
    sample();
    chk("ll3_hold_end", 0, int'(stall_if_v[0]), 0);
    advance();

    // Branch beats load-use in the same cycle.
    set_ld_hazard();
    ex_br_taken = 1'b1;
    sample();
    chk("br_flush_id", 0, int'(flush_id_v[0]), 1);
    chk("br_flush_ex", 0, int'(flush_ex_v[0]), 1);
    chk("br_stall_if", 0, int'(stall_if_v[0]), 0);
    advance();
    clear_inputs();
    sample();
    chk("br_next_stall", 0, int'(stall_if_v[0]), 0);
    chk("br_next_flush_ex", 0, int'(flush_ex_v[0]), 0);
    advance();

    // x0 destination never stalls or forwards.
    clear_inputs();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_wren = 1'b1; ex_rd = 5'd0;
    id_rs1 = 5'd0; id_rs1_used = 1'b1; mem_wren = 1'b1; mem_rd = 5'd0; ex_rs1 = 5'd0;
    sample();
    chk("x0_stall", 0, int'(stall_if_v[0]), 0);
    chk("x0_fwd", 0, int'(fwd_a_v[0]), 0);
    advance();

    // Reset during cycle 2 of a LOAD_LAT=3 stall aborts it at once.
    set_ld_hazard();
    sample();
    advance();
    sample();
    chk("rstmid_pre", 0, int'(stall_if_v[0]), 1);
    rst = 1'b0;
    sample();
    chk("rstmid_stall_if", 0, int'(stall_if_v[0]), 0);
    chk("rstmid_flush_ex", 0, int'(flush_ex_v[0]), 0);
    advance();
    clear_inputs();
    rst = 1'b1;
    sample();
    chk("rstmid_after1", 0, int'(stall_if_v[0]), 0);
    advance();
    sample();
    chk("rstmid_after2", 0, int'(stall_if_v[0]), 0);
    advance();

    // 20 consecutive stall cycles saturate a 4-bit counter.
    do_reset();
    set_ld_hazard();
    for (int c = 0; c < 20; c++) begin
      sample();
      advance();
    end
    clear_inputs();
    sample();
    chk("stall_cnt_sat", 0, int'(scnt_v[0]), PERF ? 15 : 0);
    advance();

    // Randomized traffic over a small register window to provoke hazards.
    for (int c = 0; c < 1500; c++) begin
      id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
      ex_rs1 = RW'($urandom_range(0, 3)); ex_rs2 = RW'($urandom_range(0, 3));
      ex_rd  = RW'($urandom_range(0, 3)); mem_rd = RW'($urandom_range(0, 3));
      wb_rd  = RW'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_wren     = 1'($urandom_range(0, 1)); ex_is_load = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 7) == 0);
      mem_wren    = 1'($urandom_range(0, 1)); wb_wren = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 199) != 0);
      sample();
      advance();
    end
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
